fetch_unit: RTL

Instruction fetch stage for the 32-bit RV32I core. It holds the PC and issues single-outstanding requests on the instruction-memory req/gnt/rvalid interface. It presents each fetched instruction to decode with a valid/ready handshake. It consumes the branch comparator's `taken` result and the jump target resolved in execute, and redirects fetch with kill of any in-flight or buffered instruction.

---
 rtl/fetch_unit.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Holds the PC, issues one outstanding request at a time on the imem
// req/gnt/rvalid interface and presents the fetched word to decode through
// a valid/ready buffer. A taken branch or resolved jump redirects fetch and
// kills whatever is in flight or buffered.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : adds id_misalign_o; a redirect to a non-word-aligned target
//               issues no fetch, presents a flagged NOP at the unmasked target
//               and then parks until the next redirect.
//   undefined : target bits [1:0] are masked to 00.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   br_taken_i, br_target_i     taken branch and its target
//   jump_i, jump_target_i       JAL/JALR resolved in execute and its target
//   imem_req_o, imem_addr_o     fetch request and word-aligned address
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i, imem_rdata_i response strobe and instruction word
//   id_valid_o, id_ready_i      decode handshake
//   id_pc_o, id_instr_o         PC and instruction presented to decode
//   id_misalign_o               (macro only) presented entry is a misaligned target
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        id_valid_o,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic        id_misalign_o,
`endif
   input  logic        id_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_instr_o
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
`ifdef FETCH_MISALIGN_CHK_EN
   localparam bit MIS_CHK = 1'b1;
   localparam logic [XLEN-1:0] RESET_PC_INT = RESET_PC;
`else
   localparam bit MIS_CHK = 1'b0;
   localparam logic [XLEN-1:0] RESET_PC_INT = {RESET_PC[XLEN-1:2], 2'b00};
`endif

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_PARK = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              kill_q, kill_d;
   logic              imem_req_q, imem_req_d;
   logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
   logic              id_valid_q, id_valid_d;
   logic [XLEN-1:0]   id_pc_q, id_pc_d;
   logic [XLEN-1:0]   id_instr_q, id_instr_d;
`ifdef FETCH_MISALIGN_CHK_EN
   logic              id_mis_q, id_mis_d;
`endif

   logic              redirect;
   logic [XLEN-1:0]   target_raw;
   logic [XLEN-1:0]   target;
   logic              tgt_mis;
   logic              pc_q_mis;
   logic              drain_mis;
   logic              capture;
   logic              present_mis;

   // Redirect selection: branch wins over jump
   assign redirect   = br_taken_i | jump_i;
   assign target_raw = br_taken_i ? br_target_i : jump_target_i;
   assign tgt_mis    = MIS_CHK && (target_raw[1:0] != 2'b00);
   assign pc_q_mis   = MIS_CHK && (pc_q[1:0] != 2'b00);
   assign target     = MIS_CHK ? target_raw : {target_raw[XLEN-1:2], 2'b00};
   // Destination after a killed response drains: the newest target decides
   assign drain_mis  = redirect ? tgt_mis : pc_q_mis;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC_INT;
         kill_q      <= 1'b0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= RESET_PC_INT;
         id_valid_q  <= 1'b0;
         id_pc_q     <= '0;
         id_instr_q  <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
         id_mis_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_q      <= kill_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         id_valid_q  <= id_valid_d;
         id_pc_q     <= id_pc_d;
         id_instr_q  <= id_instr_d;
`ifdef FETCH_MISALIGN_CHK_EN
         id_mis_q    <= id_mis_d;
`endif
      end
   end

   // Next state, PC and kill tracking
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      capture     = 1'b0;
      present_mis = 1'b0;
      case (state_q)
         S_REQ: begin
            if (imem_req_q) begin
               // Request is on the bus: it cannot be retracted, so mark it dead
               if (redirect) begin
                  pc_d   = target;
                  kill_d = 1'b1;
               end
               if (imem_gnt_i) state_d = S_WAIT;
            end else if (redirect) begin
               // Nothing issued yet (first cycle after reset): retarget freely
               pc_d = target;
               if (tgt_mis) begin
                  state_d     = S_HOLD;
                  present_mis = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               if (kill_q || redirect) begin
                  if (redirect) pc_d = target;
                  kill_d = 1'b0;
                  if (drain_mis) begin
                     state_d     = S_HOLD;
                     present_mis = 1'b1;
                  end else begin
                     state_d = S_REQ;
                  end
               end else begin
                  capture = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (redirect) begin
               pc_d   = target;
               kill_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d = target;
               if (tgt_mis) present_mis = 1'b1;
               else         state_d     = S_REQ;
            end else if (id_ready_i) begin
               // A misaligned entry has no successor to fetch
               if (pc_q_mis) begin
                  state_d = S_PARK;
               end else begin
                  pc_d    = pc_q + PC_STEP;
                  state_d = S_REQ;
               end
            end
         end
         S_PARK: begin
            if (redirect) begin
               pc_d = target;
               if (tgt_mis) begin
                  state_d     = S_HOLD;
                  present_mis = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   // Registered output values
   always_comb begin
      imem_req_d = (state_d == S_REQ);
      // An ungranted request keeps its address; otherwise follow the PC
      imem_addr_d = (state_q == S_REQ && imem_req_q) ? imem_addr_q
                                                     : {pc_d[XLEN-1:2], 2'b00};
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
`ifdef FETCH_MISALIGN_CHK_EN
      id_mis_d   = id_mis_q;
`endif
      if (state_q == S_HOLD && (redirect || id_ready_i)) begin
         id_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
         id_mis_d   = 1'b0;
`endif
      end
      if (capture) begin
         id_valid_d = 1'b1;
         id_pc_d    = pc_q;
         id_instr_d = imem_rdata_i;
      end
      if (present_mis) begin
         id_valid_d = 1'b1;
         id_pc_d    = pc_d;
         id_instr_d = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
         id_mis_d   = 1'b1;
`endif
      end
   end

   assign imem_req_o  = imem_req_q;
   assign imem_addr_o = imem_addr_q;
   assign id_valid_o  = id_valid_q;
   assign id_pc_o     = id_pc_q;
   assign id_instr_o  = id_instr_q;
`ifdef FETCH_MISALIGN_CHK_EN
   assign id_misalign_o = id_mis_q;
`endif

endmodule
